// File: rtl/fft_result_reader.sv
// Unloads one FFT frame from two 512-word banks into a valid/ready stream.
// Define FFT_READER_BITREV_EN to read bit-reversed-order results.
module fft_result_reader #(
   parameter int FFT_N             = 10,
   parameter int FFT_DW            = 16,
   parameter int FFT_MAX_BIT_WIDTH = 5
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         start,
   input  logic [FFT_MAX_BIT_WIDTH-1:0] ibfp,
   output logic                         busy,
   output logic                         done,
   output logic                         ract_ram0,
   output logic                         ract_ram1,
   output logic [FFT_N-2:0]             ra_ram0,
   output logic [FFT_N-2:0]             ra_ram1,
   input  logic [2*FFT_DW-1:0]          rdr_ram0,
   input  logic [2*FFT_DW-1:0]          rdr_ram1,
   output logic                         o_valid,
   input  logic                         o_ready,
   output logic [FFT_DW-1:0]            o_real,
   output logic [FFT_DW-1:0]            o_imag,
   output logic [FFT_N-1:0]             o_index,
   output logic                         o_last,
   output logic [FFT_MAX_BIT_WIDTH-1:0] o_exp
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_READ  = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;

   typedef struct packed {
      logic              last;
      logic [FFT_N-1:0]  idx;
      logic [FFT_DW-1:0] re;
      logic [FFT_DW-1:0] im;
   } ent_t;

   logic [1:0]                   state_q;
   logic [FFT_N-1:0]             rd_k_q;
   logic                         infl_q;
   logic [FFT_N-1:0]             infl_idx_q;
   logic                         infl_bank_q;
   logic [1:0]                   cnt_q;
   ent_t                         head_q;
   ent_t                         skid_q;
   logic [FFT_MAX_BIT_WIDTH-1:0] exp_q;
   logic                         done_q;

   logic [FFT_N-1:0]    phys;
   logic                bank;
   logic                pop;
   logic                push;
   logic                issue;
   logic [2:0]          occ;
   logic [2*FFT_DW-1:0] rdat;
   ent_t                in_e;

   function automatic logic [FFT_N-1:0] bitrev(input logic [FFT_N-1:0] v);
      logic [FFT_N-1:0] r;
      for (int i = 0; i < FFT_N; i++)
         r[i] = v[FFT_N-1-i];
      return r;
   endfunction

`ifdef FFT_READER_BITREV_EN
   assign phys = bitrev(rd_k_q);
`else
   assign phys = rd_k_q;
`endif

   assign bank = phys[FFT_N-1];

   // Credit check counts buffered words plus the word still in the RAM pipe.
   assign pop   = o_valid && o_ready;
   assign push  = infl_q;
   assign occ   = {1'b0, cnt_q} + {2'b00, infl_q};
   assign issue = (state_q == S_READ) && ((occ - {2'b00, pop}) < 3'd2);

   assign ract_ram0 = issue && !bank;
   assign ract_ram1 = issue && bank;
   assign ra_ram0   = phys[FFT_N-2:0];
   assign ra_ram1   = phys[FFT_N-2:0];

   assign rdat      = infl_bank_q ? rdr_ram1 : rdr_ram0;
   assign in_e.last = &infl_idx_q;
   assign in_e.idx  = infl_idx_q;
   assign in_e.re   = rdat[2*FFT_DW-1:FFT_DW];
   assign in_e.im   = rdat[FFT_DW-1:0];

   assign busy    = (state_q != S_IDLE);
   assign done    = done_q;
   assign o_valid = (cnt_q != 2'd0);
   assign o_real  = head_q.re;
   assign o_imag  = head_q.im;
   assign o_index = head_q.idx;
   assign o_last  = head_q.last;
   assign o_exp   = exp_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         rd_k_q  <= '0;
         exp_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         done_q <= pop && o_last;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_q <= S_READ;
                  exp_q   <= ibfp;
                  rd_k_q  <= '0;
               end
            end
            S_READ: begin
               if (issue) begin
                  rd_k_q <= rd_k_q + 1'b1;
                  if (&rd_k_q)
                     state_q <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (pop && o_last)
                  state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         infl_q      <= 1'b0;
         infl_idx_q  <= '0;
         infl_bank_q <= 1'b0;
      end else begin
         infl_q <= issue;
         if (issue) begin
            infl_idx_q  <= rd_k_q;
            infl_bank_q <= bank;
         end
      end
   end

   // head_q is what the consumer sees; skid_q catches the word that was
   // already in flight when the consumer stalled.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q  <= 2'd0;
         head_q <= '0;
         skid_q <= '0;
      end else begin
         case (cnt_q)
            2'd0: begin
               if (push) begin
                  head_q <= in_e;
                  cnt_q  <= 2'd1;
               end
            end
            2'd1: begin
               if (push && pop) begin
                  head_q <= in_e;
               end else if (push) begin
                  skid_q <= in_e;
                  cnt_q  <= 2'd2;
               end else if (pop) begin
                  cnt_q <= 2'd0;
               end
            end
            2'd2: begin
               if (push && pop) begin
                  head_q <= skid_q;
                  skid_q <= in_e;
               end else if (pop) begin
                  head_q <= skid_q;
                  cnt_q  <= 2'd1;
               end
            end
            default: cnt_q <= 2'd0;
         endcase
      end
   end

endmodule

// File: tb/tb_fft_result_reader.sv
// Scoreboard bench for fft_result_reader: random RAM contents and backpressure
// against a per-frame list of expected samples.
module tb_fft_result_reader;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [4:0]  ibfp = '0;
   logic        busy, done;
   logic        ract_ram0, ract_ram1;
   logic [8:0]  ra_ram0, ra_ram1;
   logic [31:0] rdr_ram0 = '0;
   logic [31:0] rdr_ram1 = '0;
   logic        o_valid;
   logic        o_ready = 1'b1;
   logic [15:0] o_real, o_imag;
   logic [9:0]  o_index;
   logic        o_last;
   logic [4:0]  o_exp;

   fft_result_reader dut (
      .clk(clk), .reset(reset), .start(start), .ibfp(ibfp),
      .busy(busy), .done(done),
      .ract_ram0(ract_ram0), .ract_ram1(ract_ram1),
      .ra_ram0(ra_ram0), .ra_ram1(ra_ram1),
      .rdr_ram0(rdr_ram0), .rdr_ram1(rdr_ram1),
      .o_valid(o_valid), .o_ready(o_ready),
      .o_real(o_real), .o_imag(o_imag), .o_index(o_index),
      .o_last(o_last), .o_exp(o_exp)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        last;
      logic [4:0]  e;
      logic [9:0]  idx;
      logic [15:0] re;
      logic [15:0] im;
   } smp_t;

   logic [31:0] mem0 [512];
   logic [31:0] mem1 [512];
   smp_t        sq [$];

   int   tests = 0;
   int   fails = 0;
   int   cyc = 0;
   int   popped = 0;
   int   reads_total = 0;
   int   done_cyc = 0;
   bit   frame_done = 0;
   bit   exp_done = 0;
   bit   held_v = 0;
   smp_t held;
   int   rmode = 0;
   int   stall_left = 0;
   bit   stalled_once = 0;
   int   reads_at = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      if (ract_ram0) rdr_ram0 <= mem0[ra_ram0];
      if (ract_ram1) rdr_ram1 <= mem1[ra_ram1];
   end

   function automatic logic [9:0] phys_of(input int k);
      logic [9:0] kv, p;
      kv = 10'(k);
`ifdef FFT_READER_BITREV_EN
      for (int i = 0; i < 10; i++) p[i] = kv[9-i];
`else
      p = kv;
`endif
      return p;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   task automatic load_mem(input bit pattern);
      for (int a = 0; a < 512; a++) begin
         if (pattern) begin
            mem0[a] = {16'(a), ~16'(a)};
            mem1[a] = {16'(a + 512), ~16'(a + 512)};
         end else begin
            mem0[a] = $urandom;
            mem1[a] = $urandom;
         end
      end
   endtask

   // Expected frame: bin k comes from physical slot p(k), in natural order.
   task automatic push_expected(input logic [4:0] e);
      logic [9:0]  p;
      logic [31:0] w;
      smp_t        s;
      for (int k = 0; k < 1024; k++) begin
         p = phys_of(k);
         w = p[9] ? mem1[p[8:0]] : mem0[p[8:0]];
         s.last = (k == 1023);
         s.e    = e;
         s.idx  = 10'(k);
         s.re   = w[31:16];
         s.im   = w[15:0];
         sq.push_back(s);
      end
   endtask

   task automatic start_frame(input logic [4:0] e);
      @(posedge clk); #1;
      start = 1'b1;
      ibfp = e;
      push_expected(e);
      popped = 0;
      frame_done = 0;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_frame(input string name);
      for (int i = 0; i < 6000 && !frame_done; i++) @(negedge clk);
      check({name, "_done_seen"}, 64'(frame_done), 64'd1);
      check({name, "_queue_empty"}, 64'(sq.size()), 64'd0);
   endtask

   task automatic wait_popped(input int n);
      for (int i = 0; i < 6000 && popped < n; i++) @(negedge clk);
      check("reach_index", 64'(popped >= n), 64'd1);
   endtask

   // Monitor: pops the scoreboard on every handshake.
   always @(negedge clk) begin
      if (reset) begin
         held_v = 0;
         exp_done = 0;
      end else begin
         if (ract_ram0 || ract_ram1) reads_total++;
         if (exp_done) begin
            check("done_pulse", 64'(done), 64'd1);
            exp_done = 0;
            frame_done = 1;
            done_cyc = cyc;
         end else begin
            check("no_spurious_done", 64'(done), 64'd0);
         end
         if (held_v) begin
            check("stall_valid", 64'(o_valid), 64'd1);
            check("stall_hold", 64'({o_last, o_exp, o_index, o_real, o_imag}),
                  64'(held));
         end
         if (o_valid && o_ready) begin
            if (sq.size() == 0) begin
               check("unexpected_sample", 64'(o_index), 64'h3ff_ffff);
            end else begin
               check("sample", 64'({o_last, o_exp, o_index, o_real, o_imag}),
                     64'(sq.pop_front()));
            end
            popped++;
            if (o_last) exp_done = 1;
            held_v = 0;
         end else if (o_valid) begin
            held_v = 1;
            held = {o_last, o_exp, o_index, o_real, o_imag};
         end else begin
            held_v = 0;
         end
      end
   end

   // Ready driver; mode 2 stalls once for 20 cycles when bin 100 is shown.
   always @(posedge clk) begin
      #1;
      case (rmode)
         1: o_ready = 1'($urandom % 2);
         2: begin
            if (stall_left > 0) begin
               stall_left--;
               if (stall_left == 0) begin
                  check("stall_reads_le2", 64'(reads_total - reads_at <= 2), 64'd1);
                  o_ready = 1'b1;
               end
            end else if (!stalled_once && o_valid && o_index == 10'd100) begin
               stalled_once = 1;
               stall_left = 20;
               reads_at = reads_total;
               o_ready = 1'b0;
            end else begin
               o_ready = 1'b1;
            end
         end
         default: o_ready = 1'b1;
      endcase
   end

   int c0;

   initial begin
      load_mem(1'b1);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_valid", 64'(o_valid), 64'd0);
      check("rst_last", 64'(o_last), 64'd0);
      check("rst_ract", 64'({ract_ram0, ract_ram1}), 64'd0);
      check("rst_index", 64'(o_index), 64'd0);
      check("rst_exp", 64'(o_exp), 64'd0);
      @(posedge clk); #1;
      reset = 1'b0;

      // Pattern frame, full throughput, latency and cycle count.
      rmode = 0;
      start_frame(5'd5);
      @(negedge clk);
      c0 = cyc;
      check("busy_after_start", 64'(busy), 64'd1);
      @(negedge clk);
      check("lat_valid_e1", 64'(o_valid), 64'd0);
      @(negedge clk);
      check("lat_valid_e2", 64'(o_valid), 64'd1);
      wait_frame("pattern");
      check("throughput_cycles", 64'(done_cyc - c0), 64'd1026);
      @(negedge clk);
      check("idle_busy", 64'(busy), 64'd0);

      // Random data, random backpressure.
      load_mem(1'b0);
      rmode = 1;
      start_frame(5'($urandom_range(0, 31)));
      wait_frame("random_ready");

      // Long stall at bin 100.
      load_mem(1'b0);
      rmode = 2;
      start_frame(5'($urandom_range(0, 31)));
      wait_frame("stall");
      check("stall_happened", 64'(stalled_once), 64'd1);

      // Start re-pulsed mid-frame must be ignored.
      load_mem(1'b0);
      rmode = 0;
      start_frame(5'd3);
      wait_popped(50);
      @(posedge clk); #1;
      start = 1'b1;
      ibfp = 5'd7;
      @(posedge clk); #1;
      start = 1'b0;
      wait_frame("restart_ignored");

      // Reset mid-frame, then a fresh frame.
      load_mem(1'b0);
      rmode = 1;
      start_frame(5'd9);
      wait_popped(300);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      sq.delete();
      frame_done = 0;
      @(negedge clk);
      check("abort_valid", 64'(o_valid), 64'd0);
      check("abort_busy", 64'(busy), 64'd0);
      repeat (5) @(negedge clk);
      check("abort_no_done", 64'(frame_done), 64'd0);
      load_mem(1'b1);
      rmode = 0;
      start_frame(5'd2);
      wait_frame("after_reset");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/fft_result_reader.md
FFT_RESULT_READER -- requirements
Module: fft_result_reader

Interface
REQ-001 Parameter FFT_N, default 10, log2 of FFT length (1024 points across two banks of 512 words).
REQ-002 Parameter FFT_DW, default 16, width of each real/imag component.
REQ-003 Parameter FFT_MAX_BIT_WIDTH, default 5, width of block-floating-point exponent.
REQ-004 clk  input  1  sole clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  single-cycle request to unload one completed FFT frame.
REQ-007 ibfp  input  FFT_MAX_BIT_WIDTH  frame exponent from the last FFT stage; sampled with start.
REQ-008 busy  output  1  high from accepted start until the last sample handshakes.
REQ-009 done  output  1  one-cycle pulse in the cycle after the last sample handshakes.
REQ-010 ract_ram0 / ract_ram1  output  1  read enables for bank 0 / bank 1.
REQ-011 ra_ram0 / ra_ram1  output  FFT_N-1  read addresses for bank 0 / bank 1.
REQ-012 rdr_ram0 / rdr_ram1  input  2*FFT_DW  read data, valid one cycle after ract; real in [2*FFT_DW-1:FFT_DW], imag in [FFT_DW-1:0].
REQ-013 o_valid  output  1  output sample valid.
REQ-014 o_ready  input  1  downstream accepts sample; handshake = o_valid && o_ready.
REQ-015 o_real / o_imag  output  FFT_DW  signed sample components.
REQ-016 o_index  output  FFT_N  natural-order bin index of the sample.
REQ-017 o_last  output  1  high with the sample whose o_index = 2^FFT_N-1.
REQ-018 o_exp  output  FFT_MAX_BIT_WIDTH  exponent latched at start; constant for the frame.

Function
REQ-019 FSM states IDLE, READ, DRAIN; IDLE->READ on start; READ->DRAIN after read of bin 2^FFT_N-1 issued; DRAIN->IDLE on handshake with o_last.
REQ-020 start in READ or DRAIN is ignored; no restart, no exponent change.
REQ-021 Bin k (physical index p, see REQ-031) is read from bank p[FFT_N-1] at address p[FFT_N-2:0]; only the selected bank's ract is high.
REQ-022 Reads issue in increasing k, at most one per cycle, only when the output buffer can accept the returning word.
REQ-023 Output path is a two-entry skid buffer; in-flight read data is never lost or duplicated under backpressure.
REQ-024 Latency: o_valid rises in the second cycle after the cycle in which start is sampled high (start at edge E0 -> o_valid at E2), given an empty buffer.
REQ-025 Throughput: with o_ready held high, one sample per cycle, 2^FFT_N samples in 2^FFT_N consecutive cycles.
REQ-026 While o_valid && !o_ready: o_real, o_imag, o_index, o_last, o_exp held stable.
REQ-027 o_valid never drops without a handshake.
REQ-028 Every index 0..2^FFT_N-1 emitted exactly once per frame, in increasing order.

Reset
REQ-029 On reset: state IDLE, busy 0, done 0, o_valid 0, o_last 0, ract_ram0/1 0, o_index 0, o_exp 0; skid buffer emptied.
REQ-030 Reset mid-frame aborts immediately: no further reads, no partial-frame done pulse, next start begins at index 0.

Configuration
REQ-031 Macro FFT_READER_BITREV_EN: defined -> physical index p = bit-reverse of k over FFT_N bits (unload of bit-reversed-order result); undefined -> p = k; o_index = k in both cases.

Verification
REQ-032 Bank 0 word a = {a, ~a}, bank 1 word a = {a+512, ~(a+512)}, start with ibfp=5, o_ready=1, macro undefined -> 1024 samples index 0..1023, o_real = index, o_exp = 5, o_last only at 1023, done one cycle after.
REQ-033 Same preload, macro defined -> at index 1 o_real = 512; at index 2 o_real = 256; at index 1023 o_real = 1023.
REQ-034 o_ready random 50% -> identical 1024-sample sequence, outputs stable on every stalled cycle, no gaps in o_index.
REQ-035 o_ready low for 20 cycles at index 100 -> at most 2 reads beyond index 100 issued during stall, index 100 held, resume without loss.
REQ-036 Reset asserted at index 300 -> o_valid 0 next cycle, no done; new start with ibfp=2 -> frame restarts at index 0 with o_exp = 2.
REQ-037 start re-pulsed at index 50 with ibfp=7 -> ignored; o_exp unchanged, sequence continues to 1023.
